// File: rtl/data_mem_unit.sv
// Data-memory responder for the RV32 execute stage.
// Owns a word-organised synchronous RAM and serves byte/half/word loads and
// stores with little-endian lanes. An access that crosses a word boundary is
// split into two aligned word accesses; stall is high while the second half
// is outstanding. Loads return one cycle after the last RAM read.
module data_mem_unit #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_r_en,
    input  logic              d_w_en,
    input  logic [31:0]       d_add,
    input  logic [2:0]        f3,
    input  logic [31:0]       d_wdata,
    input  logic [4:0]        alu_rd,
    output logic [31:0]       ld_data,
    output logic              ld_reg_w_en,
    output logic [4:0]        ld_rd,
    output logic              stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPLIT_LD = 2'd1,
        SPLIT_ST = 2'd2
    } state_t;

    // Word RAM; contents are deliberately not reset.
    logic [31:0]       mem_r [DEPTH];

    state_t            state_r;
    logic              ld_reg_w_en_r;
    logic [4:0]        ld_rd_r;

    // Load capture: low/high words of the access, byte offset, type, dest reg
    logic [31:0]       lo_word_r;
    logic [31:0]       hi_word_r;
    logic [1:0]        off_r;
    logic [2:0]        f3_r;
    logic [4:0]        rd_r;
    logic [ADDR_W-1:0] ld_idx_r;

    // Store capture: second-word lanes and data of a split store
    logic [ADDR_W-1:0] st_idx_r;
    logic [3:0]        st_be_r;
    logic [31:0]       st_data_r;

    // Request decode
    logic [1:0]        off_s;
    logic [ADDR_W-1:0] idx_s;
    logic [ADDR_W-1:0] idx_next_s;
    logic [3:0]        size_mask_s;
    logic              misalign_s;
    logic              ld_ok_s;
    logic              st_ok_s;
    logic              do_ld_s;
    logic              do_st_s;
    logic [7:0]        be_wide_s;
    logic [63:0]       data_wide_s;

    // RAM write port
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [3:0]        wr_be_s;
    logic [31:0]       wr_data_s;

    // Load result path
    logic [31:0]       raw_s;

    // Upper address bits select nothing inside this RAM.
    logic              unused_addr_s;
    assign unused_addr_s = ^d_add[31:ADDR_W+2];

    // Sign/zero extension of the right-aligned raw load value by access type.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [2:0]  typ);
        logic [31:0] res;
        case (typ)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b010:  res = raw;
            3'b100:  res = {24'h00_0000, raw[7:0]};
            3'b101:  res = {16'h0000, raw[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign off_s      = d_add[1:0];
    assign idx_s      = d_add[ADDR_W+1:2];
    assign idx_next_s = idx_s + ADDR_W'(1);

    // Access size mask and word-boundary crossing for the current request.
    always_comb begin
        size_mask_s = 4'b0000;
        misalign_s  = 1'b0;
        case (f3[1:0])
            2'b00: begin
                size_mask_s = 4'b0001;
                misalign_s  = 1'b0;
            end
            2'b01: begin
                size_mask_s = 4'b0011;
                misalign_s  = (off_s == 2'd3);
            end
            2'b10: begin
                size_mask_s = 4'b1111;
                misalign_s  = (off_s != 2'd0);
            end
            default: begin
                size_mask_s = 4'b0000;
                misalign_s  = 1'b0;
            end
        endcase
    end

    // Legal f3 encodings for loads and for stores.
    always_comb begin
        ld_ok_s = 1'b0;
        st_ok_s = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: begin
                ld_ok_s = 1'b1;
                st_ok_s = 1'b1;
            end
            3'b100, 3'b101: begin
                ld_ok_s = 1'b1;
                st_ok_s = 1'b0;
            end
            default: begin
                ld_ok_s = 1'b0;
                st_ok_s = 1'b0;
            end
        endcase
    end

    // A store wins when both enables are high; requests only land in IDLE.
    assign do_st_s = (state_r == IDLE) && d_w_en && st_ok_s;
    assign do_ld_s = (state_r == IDLE) && d_r_en && !d_w_en && ld_ok_s;

    // Lane enables and data over a two-word window: [3:0]/[31:0] hit word idx,
    // [7:4]/[63:32] spill into word idx+1.
    assign be_wide_s   = {4'b0000, size_mask_s} << off_s;
    assign data_wide_s = {32'h0000_0000, d_wdata} << {off_s, 3'b000};

    // Write-port mux: the pending second half of a split store, else the request.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = idx_s;
        wr_be_s   = be_wide_s[3:0];
        wr_data_s = data_wide_s[31:0];
        if (state_r == SPLIT_ST) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = st_idx_r;
            wr_be_s   = st_be_r;
            wr_data_s = st_data_r;
        end else begin
            wr_en_s   = do_st_s;
            wr_idx_s  = idx_s;
            wr_be_s   = be_wide_s[3:0];
            wr_data_s = data_wide_s[31:0];
        end
    end

    // Byte-lane masked RAM write.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_s[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Sequencer: captures requests, performs synchronous reads, and produces
    // the one-cycle load-return pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            ld_reg_w_en_r <= 1'b0;
            ld_rd_r       <= 5'd0;
            lo_word_r     <= 32'h0000_0000;
            hi_word_r     <= 32'h0000_0000;
            off_r         <= 2'd0;
            f3_r          <= 3'd0;
            rd_r          <= 5'd0;
            ld_idx_r      <= '0;
            st_idx_r      <= '0;
            st_be_r       <= 4'b0000;
            st_data_r     <= 32'h0000_0000;
        end else begin
            ld_reg_w_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (do_st_s) begin
                        if (misalign_s) begin
                            st_idx_r  <= idx_next_s;
                            st_be_r   <= be_wide_s[7:4];
                            st_data_r <= data_wide_s[63:32];
                            state_r   <= SPLIT_ST;
                        end
                    end else if (do_ld_s) begin
                        lo_word_r <= mem_r[idx_s];
                        off_r     <= off_s;
                        f3_r      <= f3;
                        rd_r      <= alu_rd;
                        if (misalign_s) begin
                            ld_idx_r <= idx_next_s;
                            state_r  <= SPLIT_LD;
                        end else begin
                            ld_reg_w_en_r <= 1'b1;
                            ld_rd_r       <= alu_rd;
                        end
                    end
                end
                SPLIT_LD: begin
                    hi_word_r     <= mem_r[ld_idx_r];
                    ld_reg_w_en_r <= 1'b1;
                    ld_rd_r       <= rd_r;
                    state_r       <= IDLE;
                end
                SPLIT_ST: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // The access window starts at byte off of the low word; an aligned access
    // never reaches into the high word, so its stale contents are harmless.
    assign raw_s       = 32'({hi_word_r, lo_word_r} >> {off_r, 3'b000});
    assign ld_data     = extend_load(raw_s, f3_r);
    assign ld_reg_w_en = ld_reg_w_en_r;
    assign ld_rd       = ld_rd_r;
    assign stall       = (state_r != IDLE);

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory responder for the RV32 execute stage. It accepts the execute stage's level-signalled load/store requests: d_r_en, d_w_en, d_add, f3, store data and destination register.
- It owns a word-organised synchronous data RAM and performs byte, half and word accesses with little-endian byte lanes.
- Loads return sign- or zero-extended write-back data to the register file.
- A misaligned access is split into two aligned word accesses, with stall asserted during the split.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; must be a power of two.
- ADDR_W, 10, log2(DEPTH); the word index is d_add[ADDR_W+1:2].

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- d_r_en  in  1  load request, sampled on the edge when stall=0.
- d_w_en  in  1  store request, sampled on the edge when stall=0.
- d_add  in  32  byte address.
- f3  in  3  access type: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- d_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- alu_rd  in  5  load destination register.
- ld_data  out  32  extended load result.
- ld_reg_w_en  out  1  one-cycle pulse; ld_data and ld_rd are valid.
- ld_rd  out  5  destination register of the returned load.
- stall  out  1  high while a split access is in progress; upstream holds its request.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ld_data=0; ld_reg_w_en=0; ld_rd=0; stall=0; all capture registers cleared.
  - RAM contents are not reset.
  - Reset asserted mid-split abandons the split. For a store, a half already written stays written.
- States: IDLE, SPLIT_LD, SPLIT_ST.
- Stall: stall is a combinational output, high exactly when state is SPLIT_LD or SPLIT_ST. Request inputs are ignored while stall=1.
- Offset and size: off = d_add[1:0]. Size is 1 byte for f3 x00, 2 for x01, 4 for 010.
- Misalignment: an access is misaligned if off + size > 4.
  - Misaligned half: off=3. Misaligned word: off != 0.
  - A byte access is never misaligned.
- Word index: idx = d_add[ADDR_W+1:2]. The second word of a split is (idx+1) mod DEPTH, i.e. it wraps to word 0 at the top.
- Invalid f3 (load 011/110/111; store 011-111): no RAM access, no ld_reg_w_en, state unchanged.
- d_r_en and d_w_en both high: the store is performed and the load is dropped.
- Aligned store, at edge E0:
  - The selected byte lanes of word idx are written: data shifted left by 8*off, byte enables = size mask << off.
  - Stays IDLE.
- Misaligned store:
  - E0: writes the lanes off..3 of word idx; captures the remaining data and enables; enters SPLIT_ST.
  - E1: writes the remaining low lanes of word idx+1; returns to IDLE.
- Aligned load:
  - E0: synchronous RAM read of word idx into a word register; captures off, f3 and alu_rd.
  - Cycle after E0: ld_reg_w_en=1, ld_rd=captured rd, ld_data = extract(word >> 8*off), extended per f3.
  - Latency is 1 cycle. ld_reg_w_en is 0 on every cycle without a returning load.
- Misaligned load:
  - E0: reads word idx; enters SPLIT_LD.
  - E1: reads word idx+1; returns to IDLE.
  - Cycle after E1: result = {hi_word, lo_word} >> 8*off, truncated to size and extended.
- Back-to-back aligned loads return on consecutive cycles.
- Store then load to the same address on the next edge returns the new data; there is no bypass requirement beyond RAM ordering.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.

Test Plan:
- Reset: rst=0 mid-SPLIT_LD -> stall=0 and ld_reg_w_en=0 immediately (asynchronously); the next load after release behaves normally.
- SW 0x8765_4321 @0x10, then LB/LBU/LH/LHU/LW at 0x13, 0x13, 0x12, 0x12, 0x10 -> 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x0000_8765, 0x8765_4321. Each result arrives 1 cycle after its request edge, with ld_rd matching alu_rd.
- SB 0xAA @0x21 over word 0x0000_0000 -> LW @0x20 = 0x0000_AA00; the other lanes are untouched.
- SW 0x1122_3344 @0x31 (misaligned) -> stall high for exactly 1 cycle; word 0x30 = 0x2233_44xx, word 0x34 = 0xxxxx_xx11. LW @0x31 -> 0x1122_3344 two cycles after its request edge.
- Wrap: LW at byte address 4*(DEPTH-1)+2 -> upper bytes come from word 0, no hang.
- d_r_en=d_w_en=1 -> store performed, no ld_reg_w_en pulse. f3=011 load -> no pulse, no RAM change.
